wave_gen: RTL and testbench

Sample source for the PWM DAC stage in the sound generator. A phase accumulator runs at a programmable frequency and produces an N-bit square, saw or triangle sample once per DAC PWM period. The `sample` output connects directly to the DAC `t_on` input. Frequency and waveform are loaded through a valid/ready handshake and take effect on a sample boundary.

---
 rtl/wave_gen.sv | 87 ++++++++
 tb/tb_wave_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wave_gen.sv
// wave_gen: phase-accumulator square/saw/triangle sample source for the PWM DAC stage.
// Define WAVE_GEN_ENVELOPE_EN to add a linear attack/release envelope instead of hard gating.
module wave_gen #(
  parameter int N          = 8,
  parameter int PHASE_W    = 16,
  parameter int SAMPLE_DIV = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_freq,
  input  logic [1:0]         cfg_wave,
  input  logic               gate,
  output logic [N-1:0]       sample,
  output logic               sample_strobe
);
  localparam int DW = $clog2(SAMPLE_DIV);
  logic [DW-1:0]      div_q, div_d;
  logic [PHASE_W-1:0] phase_q, phase_d, freq_act_q, freq_act_d, freq_stg_q, freq_stg_d;
  logic [1:0]         wave_act_q, wave_act_d, wave_stg_q, wave_stg_d;
  logic               pending_q, pending_d, strobe_q, strobe_d, tick, accept;
  logic [N-1:0]       sample_q, sample_d, p, tri_v, wave_v;
`ifdef WAVE_GEN_ENVELOPE_EN
  logic [N-1:0]       env_q, env_d;
  logic [2*N-1:0]     env_prod;
`endif
  always_comb begin
    tick       = div_q == DW'(SAMPLE_DIV - 1);
    accept     = cfg_valid && !pending_q;
    p          = phase_q[PHASE_W-1 -: N];
    tri_v      = {p[N-2:0], 1'b0};
    wave_v     = wave_act_q == 2'd0 ? (p[N-1] ? '0 : '1) :
                 wave_act_q == 2'd1 ? p :
                 wave_act_q == 2'd2 ? (p[N-1] ? ~tri_v : tri_v) : '0;
    div_d      = tick ? '0 : div_q + 1'b1;
    phase_d    = tick ? phase_q + freq_act_q : phase_q;
    freq_act_d = tick && pending_q ? freq_stg_q : freq_act_q;
    wave_act_d = tick && pending_q ? wave_stg_q : wave_act_q;
    freq_stg_d = accept ? cfg_freq : freq_stg_q;
    wave_stg_d = accept ? cfg_wave : wave_stg_q;
    // pending cannot be set and cleared on the same edge: accept requires it to be low
    pending_d  = accept || (pending_q && !tick);
    strobe_d   = tick;
`ifdef WAVE_GEN_ENVELOPE_EN
    env_prod   = (2*N)'(wave_v) * (2*N)'(env_q);
    sample_d   = tick ? N'(env_prod >> N) : sample_q;
    env_d      = !tick ? env_q :
                 gate  ? (&env_q ? env_q : env_q + 1'b1) :
                         (|env_q ? env_q - 1'b1 : env_q);
`else
    sample_d   = tick ? (gate ? wave_v : '0) : sample_q;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      phase_q    <= '0;
      freq_act_q <= '0;
      wave_act_q <= 2'd3;
      freq_stg_q <= '0;
      wave_stg_q <= '0;
      pending_q  <= 1'b0;
      strobe_q   <= 1'b0;
      sample_q   <= '0;
`ifdef WAVE_GEN_ENVELOPE_EN
      env_q      <= '0;
`endif
    end else begin
      div_q      <= div_d;
      phase_q    <= phase_d;
      freq_act_q <= freq_act_d;
      wave_act_q <= wave_act_d;
      freq_stg_q <= freq_stg_d;
      wave_stg_q <= wave_stg_d;
      pending_q  <= pending_d;
      strobe_q   <= strobe_d;
      sample_q   <= sample_d;
`ifdef WAVE_GEN_ENVELOPE_EN
      env_q      <= env_d;
`endif
    end
  end
  assign cfg_ready     = !pending_q;
  assign sample        = sample_q;
  assign sample_strobe = strobe_q;
endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed and random stimulus for wave_gen (SAMPLE_DIV = 4) checked against an arithmetic reference model.
module tb_wave_gen;
  logic        clk = 0, reset = 0, cfg_valid = 0, gate = 0;
  logic [15:0] cfg_freq = 0;
  logic [1:0]  cfg_wave = 0;
  logic        cfg_ready, sample_strobe;
  logic [7:0]  sample;
  int          n_checks = 0, n_fail = 0;
  int          m_cnt, m_freq, m_wave, m_pend, m_sfreq, m_swave, m_sample, m_strobe, m_env, ticks;
  int unsigned m_phase;
  bit          last_acc;
  string       name;

  wave_gen #(.N(8), .PHASE_W(16), .SAMPLE_DIV(4)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_freq(cfg_freq), .cfg_wave(cfg_wave), .gate(gate),
    .sample(sample), .sample_strobe(sample_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  function automatic int wv(int w, int p);
    case (w)
      0:       return p < 128 ? 255 : 0;
      1:       return p;
      2:       return p < 128 ? 2 * p : 255 - 2 * (p - 128);
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0d expected=%0d", name, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_freq = 0; m_wave = 3; m_pend = 0;
    m_sfreq = 0; m_swave = 0; m_sample = 0; m_strobe = 0; m_env = 0;
  endtask

  task automatic check_outs();
    chk("sample", sample, m_sample);
    chk("strobe", sample_strobe, m_strobe);
    chk("ready", cfg_ready, m_pend == 0);
  endtask

  task automatic cyc();
    bit tick, acc;
    @(posedge clk);
    last_acc = 0;
    if (!reset) model_reset();
    else begin
      tick = m_cnt == 3;
      acc  = cfg_valid && m_pend == 0;
      m_strobe = tick;
      if (tick) begin
`ifdef WAVE_GEN_ENVELOPE_EN
        m_sample = (wv(m_wave, int'(m_phase / 256)) * m_env) / 256;
        m_env = gate ? (m_env < 255 ? m_env + 1 : 255) : (m_env > 0 ? m_env - 1 : 0);
`else
        m_sample = gate ? wv(m_wave, int'(m_phase / 256)) : 0;
`endif
        m_phase = (m_phase + m_freq) % 65536;
        if (m_pend != 0) begin m_freq = m_sfreq; m_wave = m_swave; m_pend = 0; end
        ticks++;
      end
      if (acc) begin m_sfreq = cfg_freq; m_swave = cfg_wave; m_pend = 1; last_acc = 1; end
      m_cnt = (m_cnt + 1) % 4;
    end
    #1;
    check_outs();
  endtask

  task automatic load(input int f, input int w);
    bit ok = 0;
    cfg_valid = 1; cfg_freq = 16'(f); cfg_wave = 2'(w);
    for (int i = 0; i < 20 && !ok; i++) begin cyc(); ok = last_acc; end
    cfg_valid = 0;
    chk("load_accepted", ok, 1);
  endtask

  task automatic run_ticks(input int n);
    repeat (n * 4) cyc();
  endtask

  initial begin
    int first, k, s[$];
    bit a_acc, b_acc;
    model_reset();
    ticks = 0;
    name = "reset";
    #1;
    check_outs();
    repeat (5) begin
      cfg_valid = 1'($urandom); cfg_freq = 16'($urandom); cfg_wave = 2'($urandom); gate = 1'($urandom);
      cyc();
    end

    name = "saw";
    reset = 1; cfg_valid = 1; cfg_freq = 16'h0100; cfg_wave = 2'd1; gate = 1;
    first = -1; k = 0;
    for (int i = 1; i <= 260 * 4; i++) begin
      cyc();
      cfg_valid = 0;
      if (sample_strobe && first < 0) first = i;
      if (m_strobe != 0) begin
        k++;
        chk("saw_value", sample, k < 2 ? 0 : (k - 2) % 256);
      end
    end
    chk("first_strobe_clk", first, 4);

    name = "square";
    load(16'h4000, 0);
    run_ticks(3);
    s.delete();
    for (int i = 0; i < 12 * 4; i++) begin
      cyc();
      if (sample_strobe) s.push_back(int'(sample));
    end
    for (int j = 2; j < s.size(); j++) chk("square_pattern", s[j], 255 - s[j - 2]);

    name = "triangle";
    load(16'h0800, 2);
    run_ticks(40);

    name = "handshake";
    while (m_cnt != 1) cyc();
    a_acc = 0; b_acc = 0; cfg_valid = 1;
    for (int i = 0; i < 12 && !b_acc; i++) begin
      cfg_freq = a_acc ? 16'h0200 : 16'h0300;
      cfg_wave = a_acc ? 2'd2 : 2'd1;
      cyc();
      if (last_acc) begin if (!a_acc) a_acc = 1; else b_acc = 1; end
    end
    cfg_valid = 0;
    chk("hs_b_accepted", b_acc, 1);
    run_ticks(3);

    name = "tick_accept";
    while (m_cnt != 3) cyc();
    cfg_valid = 1; cfg_freq = 16'h1000; cfg_wave = 2'd0;
    cyc();
    cfg_valid = 0;
    chk("accepted_on_tick", sample_strobe && !cfg_ready, 1);
    run_ticks(3);

    name = "random";
    repeat (400) begin
      cfg_valid = 1'($urandom); cfg_freq = 16'($urandom); cfg_wave = 2'($urandom);
      gate = ($urandom_range(0, 7) != 0);
      cyc();
    end
    cfg_valid = 0;

    name = "gate_off";
    load(16'h0100, 1);
    gate = 1;
    run_ticks(4);
    gate = 0;
    for (int i = 0; i < 8 && !sample_strobe; i++) cyc();
    chk("gate_off_sample", sample, 0);

    name = "async_reset";
    gate = 1;
    load(16'h0100, 1);
    run_ticks(6);
    while (m_cnt != 1) cyc();
    cfg_valid = 1; cfg_freq = 16'h2000; cfg_wave = 2'd0;
    cyc();
    cfg_valid = 0;
    chk("pending_before_reset", cfg_ready, 0);
    #2 reset = 0;
    #1;
    model_reset();
    chk("async_sample", sample, 0);
    chk("async_strobe", sample_strobe, 0);
    chk("async_ready", cfg_ready, 1);
    cyc();
    cyc();
    reset = 1;
    run_ticks(4);

`ifdef WAVE_GEN_ENVELOPE_EN
    name = "envelope";
    load(16'h4000, 0);
    gate = 1;
    run_ticks(280);
    gate = 0;
    run_ticks(280);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
